wide_alu_seq: RTL and testbench
===============================

# wide_alu_seq

Multi-cycle, multi-precision add/subtract unit that processes operands of LIMBS×DATA_BITS bits one DATA_BITS-wide limb per cycle, least-significant limb first, propagating the carry between limbs. It is the issuing end of the single-limb adder contract. It breaks wide operations into chained limb add/subtract steps and collects the chained carry and zero flag, with a start/busy/done handshake toward the control path. Arithmetic per limb follows the processor's adder rule: subtract is a + ~b + carry, and carry-out = 1 means no borrow.

## Interface
- DATA_BITS, 8, width of one limb
- LIMBS, 4, number of limbs; operand width W = DATA_BITS*LIMBS (LIMBS ≥ 1)

- clk  input  1  clock; all state changes on posedge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- sub  input  1  0 = add, 1 = subtract (a − b); sampled with start
- a  input  W  operand A; sampled with start
- b  input  W  operand B; sampled with start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, high in DONE
- result  output  W  final sum/difference, held until next completion
- cout  output  1  carry out of top limb (sub: 1 = no borrow)
- zero  output  1  1 when all W result bits are zero

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at an edge, capture a, b, sub into internal registers; set limb index = 0; set running carry = sub; go to RUN. Otherwise stay.
- RUN: each edge computes limb i:
  - add: {c, r_i} = a_i + b_i + c.
  - sub: {c, r_i} = a_i + ~b_i + c.
  - Widths are DATA_BITS+1, unsigned. Store r_i into the accumulator slice i and increment i.
  - At the edge processing limb LIMBS−1: load result ← full accumulator including r_{LIMBS−1}; cout ← final c; zero ← (all W result bits = 0); go to DONE.
- DONE: done=1 for exactly one cycle; next edge → IDLE unconditionally.
- start in RUN or DONE is ignored. The request is not queued. Operand and sub changes after acceptance have no effect.
- result/cout/zero change only at the final RUN edge. They hold their values across IDLE and across the RUN of a later operation until that operation completes.
- Add carry-in to limb 0 is 0; subtract carry-in to limb 0 is 1 (two's complement).
- LIMBS=1 degenerates to a single RUN cycle.
- Reset (any state, including mid-RUN): state → IDLE, busy=0, done=0, result=0, cout=0, zero=0. Accumulator, index and carry are cleared. An aborted operation never produces done.

## Timing
- Reset values: busy 0, done 0, result 0, cout 0, zero 0.
- start high at edge k (in IDLE) → busy=1 from k+1.
- Limbs are computed at edges k+1 … k+LIMBS.
- result/cout/zero become valid and done=1 after edge k+LIMBS.
- busy=0 and done=0 after edge k+LIMBS+1.
- Latency from accepting edge to done: LIMBS edges. Throughput: one operation per LIMBS+2 cycles.
- A new start asserted in the DONE cycle is ignored. It is accepted only when it is sampled in IDLE.
- Reset wins over start on the same edge.

## Test plan
With DATA_BITS=8, LIMBS=4, start pulsed one cycle at edge 0:
- Add 0x000000FF + 0x00000001 → limb carry ripples. done high after edge 4: result 0x00000100, cout 0, zero 0. busy low after edge 5.
- Add 0xFFFFFFFF + 0x00000001 → result 0x00000000, cout 1, zero 1.
- Sub 0x00000100 − 0x00000001 → result 0x000000FF, cout 1. Sub 0x00000000 − 0x00000001 → result 0xFFFFFFFF, cout 0, zero 0.
- Sub 0x12345678 − 0x12345678 → result 0, cout 1, zero 1. A following add 0x1 + 0x1 must keep result 0 and zero 1 until its done, then show 0x2 and zero 0.
- Start pulsed again at edges 2 and 5 with different operands → both ignored. Only the first operation's done appears. A start at edge 6 (IDLE) is accepted.
- Reset asserted at edge 2 of an add 0xFFFFFFFF + 1 → busy 0 and all outputs 0 after edge 2. No done pulse. A subsequent operation completes normally.

Source files
------------

// File: rtl/wide_alu_seq.sv
// wide_alu_seq
//
// Multi-precision add/subtract unit. Each operation works on one DATA_BITS
// limb per cycle, least-significant limb first, and chains the carry from
// one limb to the next. For a subtract the unit computes a + ~b + 1, so a
// carry out of 1 means there was no borrow. The control path uses a
// start/busy/done handshake.
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands are captured when start is seen
// RUN   | one limb is processed per cycle, LSB limb first
// DONE  | one-cycle done pulse; result/cout/zero are already updated
//
// Ports
//   clk     in   clock; all state changes on the rising edge
//   reset   in   synchronous, active-high reset
//   start   in   operation request; accepted only in IDLE
//   sub     in   0 = add, 1 = subtract (a - b); sampled with start
//   a, b    in   W-bit operands; sampled with start
//   busy    out  high in RUN and DONE
//   done    out  one-cycle pulse in DONE
//   result  out  W-bit sum/difference; held until the next completion
//   cout    out  carry out of the top limb (subtract: 1 = no borrow)
//   zero    out  1 when every result bit is zero
module wide_alu_seq #(
  parameter int DATA_BITS = 8,
  parameter int LIMBS     = 4,
  localparam int W        = DATA_BITS * LIMBS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         zero
);

  // The index register needs at least one bit, even when LIMBS = 1.
  localparam int IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LIMBS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [W-1:0]         a_reg, b_reg, acc, acc_next;
  logic                 sub_reg;
  logic                 carry;
  logic [IDX_W-1:0]     idx;
  logic                 last_limb;
  logic [DATA_BITS-1:0] a_limb, b_limb, b_eff;
  logic [DATA_BITS:0]   limb_sum;

  // Limb datapath: one DATA_BITS+1 wide adder. The accumulator copy with
  // the current limb already merged in is what gets published as the
  // result on the last limb, so the final limb is not lost by one cycle.
  always_comb begin
    a_limb    = a_reg[idx*DATA_BITS +: DATA_BITS];
    b_limb    = b_reg[idx*DATA_BITS +: DATA_BITS];
    b_eff     = sub_reg ? ~b_limb : b_limb;
    limb_sum  = {1'b0, a_limb} + {1'b0, b_eff} + {{DATA_BITS{1'b0}}, carry};
    last_limb = (idx == LAST_IDX);
    acc_next  = acc;
    acc_next[idx*DATA_BITS +: DATA_BITS] = limb_sum[DATA_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_limb) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sub_reg <= 1'b0;
      acc     <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            sub_reg <= sub;
            idx     <= '0;
            // Subtract is a + ~b + 1, so the first carry-in equals sub.
            carry   <= sub;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= limb_sum[DATA_BITS];
          if (last_limb) begin
            idx    <= '0;
            result <= acc_next;
            cout   <= limb_sum[DATA_BITS];
            zero   <= (acc_next == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_alu_seq.sv
module tb_wide_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sub;
  logic [31:0] a, b;
  logic        busy, done, cout, zero;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  // Values the outputs are expected to hold until the next completion.
  logic [31:0] exp_result;
  logic        exp_cout, exp_zero;

  wide_alu_seq #(.DATA_BITS(8), .LIMBS(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Start one operation at the next edge (edge 0) and walk it to completion.
  task automatic run_op(input string tag, input logic op_sub, input logic [31:0] op_a,
                        input logic [31:0] op_b, input logic [31:0] r,
                        input logic c, input logic z);
    start = 1'b1; sub = op_sub; a = op_a; b = op_b;
    tick();                                   // edge 0
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; sub = ~op_sub;
    chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    chk({tag, "_done_e0"}, {31'd0, done}, 32'd0);
    tick(); tick(); tick();                   // edges 1..3
    chk({tag, "_done_e3"}, {31'd0, done}, 32'd0);
    chk({tag, "_hold_res_e3"}, result, exp_result);
    chk({tag, "_hold_zero_e3"}, {31'd0, zero}, {31'd0, exp_zero});
    chk({tag, "_hold_cout_e3"}, {31'd0, cout}, {31'd0, exp_cout});
    tick();                                   // edge 4
    chk({tag, "_done_e4"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_e4"}, {31'd0, busy}, 32'd1);
    chk({tag, "_result"}, result, r);
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, c});
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, z});
    tick();                                   // edge 5
    chk({tag, "_busy_e5"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_e5"}, {31'd0, done}, 32'd0);
    exp_result = r; exp_cout = c; exp_zero = z;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    exp_result = '0; exp_cout = 1'b0; exp_zero = 1'b0;
    tick(); tick();
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_cout",   {31'd0, cout}, 32'd0);
    chk("rst_zero",   {31'd0, zero}, 32'd0);
    reset = 1'b0;
    tick();

    run_op("add_ripple", 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0);
    run_op("add_wrap",   1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1);
    run_op("sub_borrow", 1'b1, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b1, 1'b0);
    run_op("sub_under",  1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("sub_equal",  1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1);
    // Hold checks inside run_op confirm result 0 / zero 1 persist until done.
    run_op("add_after",  1'b0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);

    // Starts during RUN (edge 2) and DONE (edge 5) must be ignored.
    start = 1'b1; sub = 1'b0; a = 32'h0000_0010; b = 32'h0000_0020;
    tick();                                   // edge 0
    start = 1'b0;
    tick();                                   // edge 1
    start = 1'b1; sub = 1'b1; a = 32'h0000_1000; b = 32'h0000_0001;
    tick();                                   // edge 2
    start = 1'b0;
    tick();                                   // edge 3
    tick();                                   // edge 4
    chk("ign_done_e4", {31'd0, done}, 32'd1);
    chk("ign_result",  result, 32'h0000_0030);
    start = 1'b1; sub = 1'b0; a = 32'h0000_0100; b = 32'h0000_0200;
    tick();                                   // edge 5 (DONE, ignored)
    chk("ign_busy_e5", {31'd0, busy}, 32'd0);
    chk("ign_done_e5", {31'd0, done}, 32'd0);
    sub = 1'b0; a = 32'h0000_0005; b = 32'h0000_0006;
    tick();                                   // edge 6 (IDLE, accepted)
    start = 1'b0;
    chk("acc_busy_e6", {31'd0, busy}, 32'd1);
    tick(); tick(); tick();                   // edges 7..9
    chk("acc_done_e9", {31'd0, done}, 32'd0);
    chk("acc_hold_e9", result, 32'h0000_0030);
    tick();                                   // edge 10
    chk("acc_done_e10", {31'd0, done}, 32'd1);
    chk("acc_result",   result, 32'h0000_000B);
    chk("acc_cout",     {31'd0, cout}, 32'd0);
    tick();
    chk("acc_busy_e11", {31'd0, busy}, 32'd0);

    // Reset in the middle of a run aborts it without a done pulse.
    start = 1'b1; sub = 1'b0; a = 32'hFFFF_FFFF; b = 32'h0000_0001;
    tick();                                   // edge 0
    start = 1'b0;
    tick();                                   // edge 1
    reset = 1'b1;
    tick();                                   // edge 2
    chk("mid_rst_busy",   {31'd0, busy}, 32'd0);
    chk("mid_rst_done",   {31'd0, done}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_cout",   {31'd0, cout}, 32'd0);
    chk("mid_rst_zero",   {31'd0, zero}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_no_done", {31'd0, done}, 32'd0);
    end
    exp_result = '0; exp_cout = 1'b0; exp_zero = 1'b0;
    run_op("post_rst", 1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
